// File: rtl/weight_buffer_if.sv
// Handshake and data bundle between the weight buffer, its loader,
// the weight updater and the forward path.
interface weight_buffer_if #(
    parameter int NEURON_NUM        = 5,
    parameter int WEIGHT_CELL_WIDTH = 16,
    parameter int COUNT_WIDTH       = 16
);
    localparam int MATRIX_WIDTH = NEURON_NUM * NEURON_NUM * WEIGHT_CELL_WIDTH;

    logic [MATRIX_WIDTH-1:0] init_w;
    logic                    init_valid;
    logic                    init_ready;
    logic [MATRIX_WIDTH-1:0] w;
    logic                    w_valid;
    logic                    w_ready;
    logic [MATRIX_WIDTH-1:0] result;
    logic                    result_valid;
    logic                    result_ready;
    logic                    error;
    logic [MATRIX_WIDTH-1:0] weights;
    logic [COUNT_WIDTH-1:0]  update_count;
    logic                    error_latched;
    logic                    busy;

    // Environment side: loader, updater and forward path.
    modport master (
        output init_w, init_valid, w_ready, result, result_valid, error,
        input  init_ready, w, w_valid, result_ready, weights, update_count,
               error_latched, busy
    );

    // Buffer side.
    modport slave (
        input  init_w, init_valid, w_ready, result, result_valid, error,
        output init_ready, w, w_valid, result_ready, weights, update_count,
               error_latched, busy
    );
endinterface

// File: rtl/weight_buffer.sv
// Weight matrix store. Holds one matrix, lends it to the weight updater
// and takes the updated copy back, counting write-backs and latching
// any overflow the updater reports.
module weight_buffer #(
    parameter int NEURON_NUM        = 5,
    parameter int WEIGHT_CELL_WIDTH = 16,
    parameter int COUNT_WIDTH       = 16
) (
    input logic           clk,
    input logic           rst,
    weight_buffer_if.slave bus
);
    localparam int CELL_NUM     = NEURON_NUM * NEURON_NUM;
    localparam int MATRIX_WIDTH = CELL_NUM * WEIGHT_CELL_WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        OFFER = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                  state_reg;
    logic                    w_valid_reg;
    logic                    result_ready_reg;
    logic                    busy_reg;
    logic                    error_latched_reg;
    logic [COUNT_WIDTH-1:0]  update_count_reg;
    logic [MATRIX_WIDTH-1:0] matrix;

    logic init_ready_int;
    logic init_fire;
    logic w_fire;
    logic result_fire;

    // In OFFER a pending w handshake wins, so init is only accepted when the
    // updater is not taking the matrix this cycle.
    assign init_ready_int = rst || (state_reg == EMPTY) ||
                            ((state_reg == OFFER) && !bus.w_ready);
    assign init_fire      = !rst && bus.init_valid && init_ready_int;
    assign w_fire         = !rst && w_valid_reg && bus.w_ready;
    assign result_fire    = !rst && result_ready_reg && bus.result_valid;

    // Cell storage: each cell is a plain copy of its slice, no arithmetic.
    // init_fire and result_fire cannot coincide (EMPTY/OFFER vs WAIT).
    for (genvar gi = 0; gi < CELL_NUM; gi++) begin : g_cell
        logic [WEIGHT_CELL_WIDTH-1:0] cell_reg;

        // Load the cell from the loader or from the updater write-back.
        always_ff @(posedge clk) begin
            if (rst) begin
                cell_reg <= '0;
            end else if (init_fire) begin
                cell_reg <= bus.init_w[gi*WEIGHT_CELL_WIDTH +: WEIGHT_CELL_WIDTH];
            end else if (result_fire) begin
                cell_reg <= bus.result[gi*WEIGHT_CELL_WIDTH +: WEIGHT_CELL_WIDTH];
            end
        end

        assign matrix[gi*WEIGHT_CELL_WIDTH +: WEIGHT_CELL_WIDTH] = cell_reg;
    end

    // Lending FSM with registered handshake/status outputs and the
    // write-back bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= EMPTY;
            w_valid_reg       <= 1'b0;
            result_ready_reg  <= 1'b0;
            busy_reg          <= 1'b0;
            update_count_reg  <= '0;
            error_latched_reg <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (init_fire) begin
                        state_reg   <= OFFER;
                        w_valid_reg <= 1'b1;
                    end
                end
                OFFER: begin
                    if (w_fire) begin
                        state_reg        <= WAIT;
                        w_valid_reg      <= 1'b0;
                        result_ready_reg <= 1'b1;
                        busy_reg         <= 1'b1;
                    end
                end
                WAIT: begin
                    if (result_fire) begin
                        state_reg        <= OFFER;
                        w_valid_reg      <= 1'b1;
                        result_ready_reg <= 1'b0;
                        busy_reg         <= 1'b0;
                        // Wraps silently at all-ones.
                        update_count_reg <= update_count_reg + COUNT_WIDTH'(1);
                        if (bus.error) begin
                            error_latched_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg        <= EMPTY;
                    w_valid_reg      <= 1'b0;
                    result_ready_reg <= 1'b0;
                    busy_reg         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.init_ready    = init_ready_int;
    assign bus.w             = matrix;
    assign bus.w_valid       = w_valid_reg;
    assign bus.result_ready  = result_ready_reg;
    assign bus.weights       = matrix;
    assign bus.update_count  = update_count_reg;
    assign bus.error_latched = error_latched_reg;
    assign bus.busy          = busy_reg;
endmodule

// File: tb/tb_weight_buffer.sv
// Scoreboard bench for weight_buffer: directed scenarios followed by
// randomized traffic, checked against a mode/matrix/count model.
module tb_weight_buffer;
    localparam int NN   = 3;
    localparam int WCW  = 16;
    localparam int CNTW = 2;
    localparam int NC   = NN * NN;
    localparam int MW   = NC * WCW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    weight_buffer_if #(.NEURON_NUM(NN), .WEIGHT_CELL_WIDTH(WCW), .COUNT_WIDTH(CNTW)) bus ();

    weight_buffer #(.NEURON_NUM(NN), .WEIGHT_CELL_WIDTH(WCW), .COUNT_WIDTH(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int n_w         = 0;

    // Reference model: 0 = empty, 1 = matrix on offer, 2 = matrix lent out.
    int              m_mode = 0;
    logic [MW-1:0]   m_mat  = '0;
    int              m_cnt  = 0;
    bit              m_err  = 1'b0;
    logic [MW-1:0]   exp_w_q[$];
    localparam logic [MW-1:0] Z = '0;

    task automatic cmp(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [MW-1:0] fill(input logic [WCW-1:0] v);
        logic [MW-1:0] m;
        for (int k = 0; k < NC; k++) m[k*WCW +: WCW] = v;
        return m;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int k = 0; k < NC; k++) m[k*WCW +: WCW] = WCW'($urandom);
        return m;
    endfunction

    task automatic check_status();
        cmp("busy",          MW'(bus.busy),          MW'(m_mode == 2));
        cmp("w_valid",       MW'(bus.w_valid),       MW'(m_mode == 1));
        cmp("result_ready",  MW'(bus.result_ready),  MW'(m_mode == 2));
        cmp("weights",       bus.weights,            m_mat);
        cmp("update_count",  MW'(bus.update_count),  MW'(m_cnt));
        cmp("error_latched", MW'(bus.error_latched), MW'(m_err));
        if (m_mode == 1) cmp("w_offered", bus.w, m_mat);
    endtask

    // One clock cycle: drive inputs, check init_ready, advance the model, check state.
    task automatic step(input bit r, input bit iv, input logic [MW-1:0] iw, input bit wr,
                        input bit rv, input logic [MW-1:0] rs, input bit er);
        logic exp_ir;
        rst              = r;
        bus.init_valid   = iv;
        bus.init_w       = iw;
        bus.w_ready      = wr;
        bus.result_valid = rv;
        bus.result       = rs;
        bus.error        = er;
        #1;
        exp_ir = r ? 1'b1 : (m_mode == 0) ? 1'b1 : (m_mode == 1) ? !wr : 1'b0;
        cmp("init_ready", MW'(bus.init_ready), MW'(exp_ir));
        if (r) begin
            m_mode = 0; m_mat = '0; m_cnt = 0; m_err = 1'b0;
        end else begin
            case (m_mode)
                0: if (iv) begin m_mat = iw; m_mode = 1; end
                1: begin
                    if (wr) begin exp_w_q.push_back(m_mat); m_mode = 2; end
                    else if (iv) m_mat = iw;
                end
                default: if (rv) begin
                    m_mat  = rs;
                    m_cnt  = (m_cnt + 1) % (1 << CNTW);
                    m_err  = m_err | er;
                    m_mode = 1;
                end
            endcase
        end
        @(posedge clk);
        #1;
        check_status();
    endtask

    // Monitor: every w handshake must deliver the next expected matrix.
    always @(negedge clk) begin : mon
        logic [MW-1:0] e;
        if ((bus.w_valid && bus.w_ready && !rst) === 1'b1) begin
            n_w++;
            if (exp_w_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL w_unexpected: got handshake with w=%h, expected none", bus.w);
            end else begin
                e = exp_w_q.pop_front();
                cmp("w_handshake", bus.w, e);
                $display("w handshake %0d: w=%h", n_w, bus.w);
            end
        end
        if ((bus.result_valid && bus.result_ready && !rst) === 1'b1)
            $display("result handshake: result=%h error=%0b", bus.result, bus.error);
    end

    initial begin
        // Reset state.
        step(1, 0, Z, 0, 0, Z, 0);
        step(1, 0, Z, 0, 0, Z, 0);

        // Initial load of all-3 matrix.
        step(0, 1, fill(16'h0003), 0, 0, Z, 0);

        // Full round trip with all-5 write-back.
        step(0, 0, Z, 1, 0, Z, 0);
        step(0, 0, Z, 0, 0, Z, 0);
        step(0, 0, Z, 0, 1, fill(16'h0005), 0);

        // init/w collision: w wins, stored matrix stays all-5.
        step(0, 1, fill(16'h0007), 1, 0, Z, 0);
        step(0, 1, fill(16'h0008), 0, 0, Z, 0);
        step(0, 0, Z, 0, 1, fill(16'h0009), 0);

        // Backpressure with stray result_valid/error pulses.
        for (int i = 0; i < 10; i++) step(0, 0, Z, 0, (i % 3 == 1), rand_mat(), 1);

        // Error on second of four round trips; counter wraps to 0.
        step(1, 0, Z, 0, 0, Z, 0);
        step(0, 1, rand_mat(), 0, 0, Z, 0);
        for (int t = 0; t < 4; t++) begin
            step(0, 0, Z, 1, 0, Z, 0);
            step(0, 0, Z, 0, 1, rand_mat(), (t == 1));
        end

        // Reset while lent, then a late result is ignored.
        step(0, 0, Z, 1, 0, Z, 0);
        step(1, 0, Z, 0, 1, rand_mat(), 1);
        step(0, 0, Z, 0, 1, fill(16'h0005), 1);
        step(0, 0, Z, 0, 1, fill(16'h0005), 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), rand_mat(),
                 ($urandom_range(0, 2) != 0), $urandom_range(0, 1), rand_mat(),
                 ($urandom_range(0, 3) == 0));
        end

        step(0, 0, Z, 0, 0, Z, 0);
        cmp("w_queue_drained", MW'(exp_w_q.size()), Z);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/weight_buffer.md
WEIGHT_BUFFER -- requirements
Module: weight_buffer

Interface
REQ-001 SHALL have parameter NEURON_NUM, default 5, meaning neurons per layer; the matrix holds NEURON_NUM*NEURON_NUM cells.
REQ-002 SHALL have parameter WEIGHT_CELL_WIDTH, default 16, meaning width of each weight cell.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, meaning width of the update counter.
REQ-004 SHALL use a single clock and a synchronous, active-high reset:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have the following data and handshake ports:
- init_w  input  NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH  initial weight matrix.
- init_valid  input  1  init_w is valid.
- init_ready  output  1  block accepts init_w.
- w  output  NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH  stored matrix offered to the weight updater.
- w_valid  output  1  w is offered.
- w_ready  input  1  updater takes w.
- result  input  NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH  updated matrix from the updater.
- result_valid  input  1  result is valid.
- result_ready  output  1  block accepts result.
- error  input  1  updater overflow flag, sampled at the result handshake.
- weights  output  NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH  stored matrix, always driven, for the forward path.
- update_count  output  COUNT_WIDTH  count of completed write-backs.
- error_latched  output  1  sticky overflow flag.
- busy  output  1  high while the stored matrix is lent out (WAIT state).

Function
REQ-006 SHALL implement a three-state FSM with states EMPTY, OFFER and WAIT.
REQ-007 SHALL define a handshake on any channel as valid and ready both high at the same rising clk edge.
REQ-008 SHALL behave in EMPTY as follows:
- init_ready=1, w_valid=0, result_ready=0.
- On an init handshake: store init_w and go to OFFER.
REQ-009 SHALL behave in OFFER as follows:
- w_valid=1 and w equals the stored matrix; result_ready=0.
- init_ready = NOT w_ready (combinational).
- On a w handshake: go to WAIT; the stored matrix is unchanged.
- On an init handshake: overwrite the stored matrix and stay in OFFER.
REQ-010 SHALL give the w handshake priority when init_valid and w_ready are both high in OFFER: no init handshake occurs, and w carries the old matrix.
REQ-011 SHALL behave in WAIT as follows:
- w_valid=0, init_ready=0, result_ready=1, busy=1.
- On a result handshake, in the same edge: store result, increment update_count, set error_latched if error=1, and go to OFFER.
REQ-012 SHALL make a write-back visible on weights and w one cycle after the result handshake, with w_valid=1 in that same cycle.
REQ-013 SHALL increment update_count modulo 2^COUNT_WIDTH, wrapping from all-ones to 0 with no flag.
REQ-014 SHALL keep error_latched high once set; only rst clears it.
REQ-015 SHALL ignore result_valid outside WAIT, ignore init_valid in WAIT, and ignore error except at a result handshake.
REQ-016 SHALL hold w stable while w_valid=1 and w_ready=0.
REQ-017 SHALL store cells bit-exact, with no arithmetic on any cell; cell k occupies bits [k*WEIGHT_CELL_WIDTH +: WEIGHT_CELL_WIDTH].

Reset
REQ-018 SHALL, when rst=1 at a rising edge, do all of the following:
- state <= EMPTY.
- Stored matrix <= 0.
- update_count <= 0.
- error_latched <= 0.
REQ-019 SHALL present these output values while in reset and after reset: init_ready=1, w_valid=0, result_ready=0, busy=0, weights=0.
REQ-020 SHALL give rst priority over every handshake in the same cycle; reset in WAIT abandons the lent matrix, and a later result_valid is ignored.

Verification
REQ-021 SHALL have a bench cover initial load: after rst, init_w with all cells 0x0003 and init_valid=1 for one cycle -> next cycle w_valid=1, weights all 0x0003, update_count=0.
REQ-022 SHALL have a bench cover a full round trip: w handshake, then result with all cells 0x0005, error=0, one cycle later -> busy=1 between the handshakes; after the write-back, weights all 0x0005, update_count=1, w_valid=1, error_latched=0.
REQ-023 SHALL have a bench cover the init/w collision: in OFFER, init_valid=1 with init_w all 0x0007 together with w_ready=1 -> init_ready=0, state WAIT, stored matrix unchanged.
REQ-024 SHALL have a bench cover backpressure: w_ready=0 for 10 cycles in OFFER, with result_valid=1 pulsed during them -> w is constant, result_ready=0, update_count unchanged.
REQ-025 SHALL have a bench cover error and wrap: with COUNT_WIDTH=2, four round trips with error=1 on the second -> error_latched=1 from the second write-back onward, and update_count=0 after the fourth.
REQ-026 SHALL have a bench cover reset mid-operation: rst asserted in WAIT, then result_valid=1 -> state EMPTY, weights=0, result_ready=0, write-back ignored.
